// File: rtl/sparse_chal_mul.sv
// Sparse challenge multiply: cs = c*s mod (X^N+1) for c with coefficients in {-1,0,1}.
// Scans c once; each nonzero coefficient adds/subtracts a rotated s, LANES coefficients per cycle.
module sparse_chal_mul #(
   parameter int N     = 256,
   parameter int LANES = 16,
   parameter int W     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [31:0]  c_in [0:N-1],
   input  logic signed [W-1:0] s_in [0:N-1],
   output logic                busy,
   output logic                done,
   output logic                bad_coef,
   output logic signed [W-1:0] out  [0:N-1]
);

   // state | meaning
   // IDLE  | waiting for first start, out all zero
   // SCAN  | testing c_in[j], one coefficient per edge
   // ACC   | accumulating chunk k of rotated s for coefficient j
   // DONE  | result valid, held until next start

   localparam int JW     = $clog2(N);
   localparam int CHUNKS = N / LANES;
   localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, ACC, DONE} state_t;

   state_t          state;
   logic [JW-1:0]   j;
   logic [KW-1:0]   k;
   logic            sgn;

   logic signed [31:0]  c_cur;
   logic                c_zero;
   logic                c_unit;
   logic                j_last;
   logic                k_last;

   logic [JW-1:0]       lane_src [LANES];
   logic [JW-1:0]       lane_dst [LANES];
   logic                lane_neg [LANES];
   logic signed [W-1:0] lane_new [LANES];

   assign c_cur  = c_in[j];
   assign c_zero = (c_cur == 32'sd0);
   assign c_unit = (c_cur == 32'sd1) || (c_cur == -32'sd1);
   assign j_last = (j == JW'(N - 1));
   assign k_last = (k == KW'(CHUNKS - 1));

   // Destination index wraps mod N; crossing X^N flips the sign of the term.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         int idx;
         int sum;
         idx         = int'(k) * LANES + l;
         sum         = idx + int'(j);
         lane_src[l] = JW'(idx);
         lane_dst[l] = JW'(sum);
         lane_neg[l] = (sum >= N) ^ sgn;
         lane_new[l] = lane_neg[l] ? (out[lane_dst[l]] - s_in[lane_src[l]])
                                   : (out[lane_dst[l]] + s_in[lane_src[l]]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bad_coef <= 1'b0;
         j        <= '0;
         k        <= '0;
         sgn      <= 1'b0;
         for (int i = 0; i < N; i++) out[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  for (int i = 0; i < N; i++) out[i] <= '0;
                  done     <= 1'b0;
                  bad_coef <= 1'b0;
                  busy     <= 1'b1;
                  j        <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (!c_zero) begin
                  k     <= '0;
                  sgn   <= c_cur[31];
                  state <= ACC;
                  if (!c_unit) bad_coef <= 1'b1;
               end else if (j_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            ACC: begin
               for (int l = 0; l < LANES; l++) out[lane_dst[l]] <= lane_new[l];
               k <= k + 1'b1;
               if (k_last) begin
                  if (j_last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     j     <= j + 1'b1;
                     state <= SCAN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sparse_chal_mul.sv
// Directed bench for sparse_chal_mul with a negacyclic reference model and result scoreboard.
module tb_sparse_chal_mul;
   localparam int N      = 256;
   localparam int LANES  = 16;
   localparam int W      = 32;
   localparam int BOUND  = 5000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic signed [31:0]  c [0:N-1];
   logic signed [W-1:0] s [0:N-1];
   logic                busy, done, bad_coef;
   logic signed [W-1:0] dout [0:N-1];

   int checks = 0;
   int failures = 0;

   logic signed [W-1:0] exp_q [$];
   int                  lat_q [$];
   bit                  bad_q [$];

   sparse_chal_mul #(.N(N), .LANES(LANES), .W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .c_in(c), .s_in(s),
      .busy(busy), .done(done), .bad_coef(bad_coef), .out(dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Direct negacyclic convolution; pushes expected coefficients, latency and bad flag.
   task automatic push_model();
      logic signed [W-1:0] acc [0:N-1];
      int nz = 0;
      bit bad = 0;
      for (int i = 0; i < N; i++) acc[i] = '0;
      for (int jj = 0; jj < N; jj++) begin
         if (c[jj] != 0) begin
            nz++;
            if (c[jj] != 1 && c[jj] != -1) bad = 1;
            for (int i = 0; i < N; i++) begin
               logic signed [W-1:0] t;
               int p;
               p = i + jj;
               t = (p < N) ? s[i] : -s[i];
               if (c[jj] < 0) t = -t;
               acc[p % N] = acc[p % N] + t;
            end
         end
      end
      for (int i = 0; i < N; i++) exp_q.push_back(acc[i]);
      lat_q.push_back(N + nz * (N / LANES));
      bad_q.push_back(bad);
   endtask

   task automatic run_op(input string tag, input int repulse);
      int edges = 0;
      int busy_err = 0;
      int elat;
      bit ebad;
      push_model();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (edges < BOUND) begin
         @(posedge clk);
         #1;
         edges++;
         start = 1'b0;
         if (done) break;
         if (busy !== 1'b1) busy_err++;
         if (edges == repulse) start = 1'b1;
      end
      elat = lat_q.pop_front();
      ebad = bad_q.pop_front();
      check({tag, "_timeout"}, done, 1'b1);
      check({tag, "_latency"}, edges, elat);
      check({tag, "_busy_run"}, busy_err, 0);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_bad"}, bad_coef, ebad);
      for (int i = 0; i < N; i++) begin
         logic signed [W-1:0] e;
         e = exp_q.pop_front();
         check($sformatf("%s_out%0d", tag, i), dout[i], e);
      end
   endtask

   task automatic check_cleared(input string tag);
      int nzo = 0;
      for (int i = 0; i < N; i++) if (dout[i] !== '0) nzo++;
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_bad"}, bad_coef, 1'b0);
      check({tag, "_out_nonzero"}, nzo, 0);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         c[i] = 0;
         s[i] = 0;
      end
   endtask

   initial begin
      clear_inputs();
      #12;
      check_cleared("reset");
      @(negedge clk);
      rst = 1'b0;

      // Out-of-range coefficient treated as sign only
      clear_inputs();
      c[5] = 3;
      s[0] = 7;
      run_op("bad3", -1);
      check("bad3_out5_direct", dout[5], 32'sd7);

      // All-zero challenge: bad flag cleared by the new start
      clear_inputs();
      for (int i = 0; i < N; i++) s[i] = i;
      run_op("zero", -1);

      // Identity
      clear_inputs();
      for (int i = 0; i < N; i++) s[i] = i;
      c[0] = 1;
      run_op("ident", -1);

      // -X times all-ones: wrap gives +1 at index 0
      clear_inputs();
      for (int i = 0; i < N; i++) s[i] = 1;
      c[1] = -1;
      run_op("negx", -1);
      check("negx_out0_direct", dout[0], 32'sd1);
      check("negx_out1_direct", dout[1], -32'sd1);

      // tau=60 challenge, s in [-2,2]
      clear_inputs();
      begin
         int cnt = 0;
         while (cnt < 60) begin
            int p;
            p = $urandom_range(0, N - 1);
            if (c[p] == 0) begin
               c[p] = ($urandom_range(0, 1) == 1) ? 1 : -1;
               cnt++;
            end
         end
      end
      for (int i = 0; i < N; i++) s[i] = $signed($urandom_range(0, 4)) - 2;
      run_op("tau60", -1);

      // Same inputs with start re-pulsed mid-operation
      run_op("repulse", 300);

      // Reset during ACC at j=100, then golden rerun
      clear_inputs();
      for (int i = 0; i < N; i++) s[i] = $signed($urandom_range(0, 4)) - 2;
      c[10] = 1;
      c[100] = -1;
      c[200] = 1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (125) @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      check_cleared("abort_async");
      @(posedge clk);
      #1;
      check_cleared("abort_next");
      @(negedge clk);
      rst = 1'b0;
      run_op("rerun", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
